// File: rtl/ddr_responder.sv
// ddr_responder
//   Responder end of the matrix_unit DDR request interface. Single-word read and
//   write requests are queued and serviced strictly in order from on-chip RAM.
//   Each response (w_done or r_valid) pulses for one cycle, Latency edges after
//   the request reaches the head of an idle unit.
// Ports
//   clk_i          clock
//   rst_ni         synchronous active-low reset (RAM contents are kept)
//   ddr_address_i  word address of the request
//   ddr_w_en_i     write request strobe
//   ddr_w_data_i   write data
//   ddr_r_en_i     read request strobe
//   ddr_ready_o    queue can accept a request this cycle
//   ddr_w_done_o   1-cycle pulse: oldest write committed
//   ddr_r_data_o   read data, valid with ddr_r_valid_o, held until the next read
//   ddr_r_valid_o  1-cycle pulse: read data valid
//   err_o          sticky protocol-error flag (drop, w+r collision, bad address)
module ddr_responder #(
  parameter int Latency    = 2,
  parameter int QueueDepth = 4,
  parameter int D          = 4,
  parameter int AddrW      = 6,
  parameter int DataW      = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] ddr_address_i,
  input  logic             ddr_w_en_i,
  input  logic [DataW-1:0] ddr_w_data_i,
  input  logic             ddr_r_en_i,
  output logic             ddr_ready_o,
  output logic             ddr_w_done_o,
  output logic [DataW-1:0] ddr_r_data_o,
  output logic             ddr_r_valid_o,
  output logic             err_o
);
  localparam int MemDepth = D * D;
  localparam int MemAW    = (MemDepth > 1) ? $clog2(MemDepth) : 1;
  localparam int PtrW     = $clog2(QueueDepth);
  localparam int CntW     = (Latency > 1) ? $clog2(Latency) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(Latency - 1);
  localparam logic [PtrW:0]   QFull   = (PtrW+1)'(QueueDepth);

  typedef struct packed {
    logic             is_write;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
  } req_t;

  typedef enum logic {IDLE, BUSY} state_t;

  req_t             q_mem [QueueDepth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [PtrW:0]    count;
  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             exec;

  logic [DataW-1:0] ram [MemDepth];

  logic req, push, err_set, head_ok, in_ok;
  req_t head;

  assign head        = q_mem[rd_ptr];
  assign head_ok     = 32'(head.addr) < MemDepth;
  assign in_ok       = 32'(ddr_address_i) < MemDepth;
  assign ddr_ready_o = count < QFull;
  assign req         = ddr_w_en_i | ddr_r_en_i;
  assign push        = req & ddr_ready_o;
  // A request flags an error if it is dropped, collides w+r, or addresses past RAM.
  assign err_set     = req & (~ddr_ready_o | (ddr_w_en_i & ddr_r_en_i) | ~in_ok);

  // Service sequencer: wait Latency edges per entry, execute head on cnt==0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0 || push) begin
          state_d = BUSY;
          cnt_d   = CntInit;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          exec = 1'b1;
          // Back-to-back service keeps responses spaced exactly Latency apart.
          if (count > (PtrW+1)'(1) || push) cnt_d = CntInit;
          else                              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      ddr_w_done_o  <= 1'b0;
      ddr_r_valid_o <= 1'b0;
      ddr_r_data_o  <= '0;
      err_o         <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) begin
        q_mem[wr_ptr] <= '{is_write: ddr_w_en_i, addr: ddr_address_i, data: ddr_w_data_i};
        wr_ptr        <= wr_ptr + PtrW'(1);
      end
      if (exec) rd_ptr <= rd_ptr + PtrW'(1);
      count <= count + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, exec};

      ddr_w_done_o  <= exec & head.is_write;
      ddr_r_valid_o <= exec & ~head.is_write;
      if (exec && !head.is_write)
        ddr_r_data_o <= head_ok ? ram[head.addr[MemAW-1:0]] : '0;
      err_o <= err_o | err_set;
    end
  end

  // RAM is not reset; writes to out-of-range addresses are discarded.
  always_ff @(posedge clk_i) begin
    if (rst_ni && exec && head.is_write && head_ok)
      ram[head.addr[MemAW-1:0]] <= head.data;
  end

endmodule

// File: tb/tb_ddr_responder.sv
// Bench for ddr_responder: directed vector table, a mid-operation reset
// sequence, then randomized traffic against a timestamp-based reference model.
module tb_ddr_responder;
  localparam int L = 2, Q = 4, MD = 16;

  logic       clk = 1'b0;
  logic       rst_ni, w_en, r_en;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic       ready, w_done, r_valid, err;
  logic [7:0] rdata;

  always #5 clk = ~clk;

  ddr_responder #(.Latency(L), .QueueDepth(Q), .D(4), .AddrW(6), .DataW(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ddr_address_i(addr), .ddr_w_en_i(w_en),
    .ddr_w_data_i(wdata), .ddr_r_en_i(r_en), .ddr_ready_o(ready),
    .ddr_w_done_o(w_done), .ddr_r_data_o(rdata), .ddr_r_valid_o(r_valid), .err_o(err)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Reference model: each accepted request is stamped with the edge at which it
  // is serviced: max(accept edge, previous service edge) + L.
  typedef struct { bit w; int a; logic [7:0] d; int resp; } ent_t;
  ent_t       pend[$];
  int         last_resp = 0, edge_n = 0;
  logic [7:0] mmem [MD];
  bit         mknown [MD];
  bit         m_wd, m_rv, m_err, m_rdy, m_rd_known;
  logic [7:0] m_rd;

  task automatic model_edge(input logic rst, w, r, input int a, input logic [7:0] d);
    bit rdy;
    ent_t e;
    edge_n++;
    if (!rst) begin
      pend.delete(); last_resp = 0;
      m_wd = 0; m_rv = 0; m_rd = 0; m_err = 0; m_rd_known = 1;
    end else begin
      rdy = pend.size() < Q;
      m_wd = 0; m_rv = 0;
      if (pend.size() > 0 && pend[0].resp == edge_n) begin
        e = pend.pop_front();
        if (e.w) begin
          m_wd = 1;
          if (e.a < MD) begin mmem[e.a] = e.d; mknown[e.a] = 1; end
        end else begin
          m_rv = 1;
          m_rd = (e.a < MD) ? mmem[e.a] : 8'h00;
          m_rd_known = (e.a >= MD) || mknown[e.a];
        end
      end
      if (w || r) begin
        if (!rdy) m_err = 1;
        else begin
          if (w && r) m_err = 1;
          if (a >= MD) m_err = 1;
          e.w = w; e.a = a; e.d = d;
          e.resp = ((edge_n > last_resp) ? edge_n : last_resp) + L;
          last_resp = e.resp;
          pend.push_back(e);
        end
      end
    end
    m_rdy = pend.size() < Q;
  endtask

  task automatic step(input logic rst, w, r, input logic [5:0] a, input logic [7:0] d);
    rst_ni = rst; w_en = w; r_en = r; addr = a; wdata = d;
    @(posedge clk);
    model_edge(rst, w, r, int'(a), d);
    #1;
    chk("mdl_ready", ready, m_rdy);
    chk("mdl_w_done", w_done, m_wd);
    chk("mdl_r_valid", r_valid, m_rv);
    chk("mdl_err", err, m_err);
    if (m_rd_known) chk("mdl_r_data", rdata, m_rd);
    rst_ni = 1'b1; w_en = 1'b0; r_en = 1'b0;
  endtask

  typedef struct {
    logic rst, w, r; logic [5:0] a; logic [7:0] d;
    logic rdy, wd, rv; logic [7:0] rd; logic er;
  } vec_t;
  vec_t tbl[44];

  function automatic vec_t row(input logic rst, w, r, input logic [5:0] a, input logic [7:0] d,
                               input logic rdy, wd, rv, input logic [7:0] rd, input logic er);
    vec_t v;
    v.rst = rst; v.w = w; v.r = r; v.a = a; v.d = d;
    v.rdy = rdy; v.wd = wd; v.rv = rv; v.rd = rd; v.er = er;
    return v;
  endfunction

  initial begin
    rst_ni = 1'b0; w_en = 1'b0; r_en = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < MD; i++) begin mmem[i] = '0; mknown[i] = 0; end

    // reset
    tbl[0]  = row(0,0,0,0,0,      1,0,0,8'h00,0);
    tbl[1]  = row(0,0,0,0,0,      1,0,0,8'h00,0);
    // write 3 / read 3
    tbl[2]  = row(1,1,0,3,8'hA5,  1,0,0,8'h00,0);
    tbl[3]  = row(1,0,0,0,0,      1,0,0,8'h00,0);
    tbl[4]  = row(1,0,0,0,0,      1,1,0,8'h00,0);
    tbl[5]  = row(1,0,1,3,0,      1,0,0,8'h00,0);
    tbl[6]  = row(1,0,0,0,0,      1,0,0,8'h00,0);
    tbl[7]  = row(1,0,0,0,0,      1,0,1,8'hA5,0);
    // fill the queue with writes, one dropped request at full
    tbl[8]  = row(1,1,0,0,8'h0A,  1,0,0,8'hA5,0);
    tbl[9]  = row(1,1,0,1,8'h0B,  1,0,0,8'hA5,0);
    tbl[10] = row(1,1,0,2,8'h0C,  1,1,0,8'hA5,0);
    tbl[11] = row(1,1,0,3,8'h0D,  1,0,0,8'hA5,0);
    tbl[12] = row(1,1,0,4,8'h0E,  1,1,0,8'hA5,0);
    tbl[13] = row(1,1,0,5,8'h0F,  0,0,0,8'hA5,0);
    tbl[14] = row(1,0,1,0,0,      1,1,0,8'hA5,1);
    tbl[15] = row(1,0,0,0,0,      1,0,0,8'hA5,1);
    tbl[16] = row(1,0,0,0,0,      1,1,0,8'hA5,1);
    tbl[17] = row(1,0,0,0,0,      1,0,0,8'hA5,1);
    tbl[18] = row(1,0,0,0,0,      1,1,0,8'hA5,1);
    tbl[19] = row(1,0,0,0,0,      1,0,0,8'hA5,1);
    tbl[20] = row(1,0,0,0,0,      1,1,0,8'hA5,1);
    // read back 0..3 in order
    tbl[21] = row(1,0,1,0,0,      1,0,0,8'hA5,1);
    tbl[22] = row(1,0,1,1,0,      1,0,0,8'hA5,1);
    tbl[23] = row(1,0,1,2,0,      1,0,1,8'h0A,1);
    tbl[24] = row(1,0,1,3,0,      1,0,0,8'h0A,1);
    tbl[25] = row(1,0,0,0,0,      1,0,1,8'h0B,1);
    tbl[26] = row(1,0,0,0,0,      1,0,0,8'h0B,1);
    tbl[27] = row(1,0,0,0,0,      1,0,1,8'h0C,1);
    tbl[28] = row(1,0,0,0,0,      1,0,0,8'h0C,1);
    tbl[29] = row(1,0,0,0,0,      1,0,1,8'h0D,1);
    // read-after-write, same address
    tbl[30] = row(1,1,0,5,8'h77,  1,0,0,8'h0D,1);
    tbl[31] = row(1,0,1,5,0,      1,0,0,8'h0D,1);
    tbl[32] = row(1,0,0,0,0,      1,1,0,8'h0D,1);
    tbl[33] = row(1,0,0,0,0,      1,0,0,8'h0D,1);
    tbl[34] = row(1,0,0,0,0,      1,0,1,8'h77,1);
    // w+r collision, then out-of-range read
    tbl[35] = row(1,1,1,6,8'h11,  1,0,0,8'h77,1);
    tbl[36] = row(1,0,0,0,0,      1,0,0,8'h77,1);
    tbl[37] = row(1,0,0,0,0,      1,1,0,8'h77,1);
    tbl[38] = row(1,0,1,6,0,      1,0,0,8'h77,1);
    tbl[39] = row(1,0,0,0,0,      1,0,0,8'h77,1);
    tbl[40] = row(1,0,0,0,0,      1,0,1,8'h11,1);
    tbl[41] = row(1,0,1,16,0,     1,0,0,8'h11,1);
    tbl[42] = row(1,0,0,0,0,      1,0,0,8'h11,1);
    tbl[43] = row(1,0,0,0,0,      1,0,1,8'h00,1);

    for (int i = 0; i < 44; i++) begin
      step(tbl[i].rst, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d_ready", i), ready, tbl[i].rdy);
      chk($sformatf("vec%0d_w_done", i), w_done, tbl[i].wd);
      chk($sformatf("vec%0d_r_valid", i), r_valid, tbl[i].rv);
      chk($sformatf("vec%0d_r_data", i), rdata, tbl[i].rd);
      chk($sformatf("vec%0d_err", i), err, tbl[i].er);
    end

    // Reset with two requests in flight: nothing may come out afterwards.
    step(1,1,0,7,8'h55);
    step(1,1,0,8,8'h66);
    step(0,0,1,7,0);
    for (int i = 0; i < 5; i++) begin
      step(1,0,0,0,0);
      chk("rst_flush_w_done", w_done, 1'b0);
      chk("rst_flush_r_valid", r_valid, 1'b0);
      chk("rst_flush_ready", ready, 1'b1);
      chk("rst_flush_err", err, 1'b0);
    end
    // RAM survives reset; a fresh request is serviced normally.
    step(1,0,1,6,0);
    step(1,0,0,0,0);
    step(1,0,0,0,0);
    chk("post_rst_r_valid", r_valid, 1'b1);
    chk("post_rst_r_data", rdata, 8'h11);
    chk("post_rst_err", err, 1'b0);
    // collision on a clean error flag
    step(1,1,1,9,8'h3C);
    chk("collide_err", err, 1'b1);
    step(1,0,0,0,0);
    step(1,0,0,0,0);
    chk("collide_w_done", w_done, 1'b1);
    chk("collide_r_valid", r_valid, 1'b0);

    // Randomized traffic with varying request density and rare resets.
    for (int i = 0; i < 3000; i++) begin
      int dens;
      logic w, r, rs;
      logic [5:0] a;
      dens = (i / 250) % 4 + 1;
      rs = ($urandom_range(0, 399) != 0);
      w  = ($urandom_range(0, 7) < dens);
      r  = ($urandom_range(0, 7) < dens) && ($urandom_range(0, 3) != 0 || !w);
      a  = ($urandom_range(0, 15) == 0) ? 6'(16 + $urandom_range(0, 3)) : 6'($urandom_range(0, 15));
      step(rs, w, r, a, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
